// File: rtl/laser_cover_gen.sv
`default_nettype none
// laser_cover_gen: loads a frame of points, then alternately refines two circle centres to maximise union coverage.
// Rev 1.0

module laser_cover_gen #(
  parameter int CW       = 4,
  parameter int N_PTS    = 40,
  parameter int R_SQ     = 16,
  parameter int MAX_ITER = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       VALID,
  input  logic [CW-1:0]              X,
  input  logic [CW-1:0]              Y,
  output logic                       READY,
  output logic [CW-1:0]              C1X,
  output logic [CW-1:0]              C1Y,
  output logic [CW-1:0]              C2X,
  output logic [CW-1:0]              C2Y,
  output logic [$clog2(N_PTS+1)-1:0] COUNT,
  output logic                       DONE
);

  localparam int CNTW = $clog2(N_PTS + 1);
  localparam int IW   = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam int ITW  = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_PTS - 1);
  localparam logic [ITW-1:0] ITER_LIM = ITW'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN1 = 3'd2,
    SCAN2 = 3'd3,
    CHECK = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   pt_x [N_PTS];
  logic [CW-1:0]   pt_y [N_PTS];
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cx, cy;
  logic [CW-1:0]   c1x, c1y, c2x, c2y;
  logic [CW-1:0]   s1x, s1y, s2x, s2y;
  logic [CW-1:0]   bx, by;
  logic [CNTW-1:0] cnt, best, final_cnt;
  logic [ITW-1:0]  iter;

  logic [CW-1:0]   fix_x, fix_y, win_x, win_y;
  logic            hit, better, last_pt, last_cand, converged;
  logic [CNTW-1:0] total;
  logic [ITW-1:0]  iter_next;

  // dx/dy are absolute differences; the sum is one bit wider than a square so it cannot wrap.
  function automatic logic covered(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                   input logic [CW-1:0] px, input logic [CW-1:0] py);
    logic [CW-1:0]   dx, dy;
    logic [2*CW-1:0] dxe, dye;
    logic [2*CW:0]   s;
    dx  = (ax >= px) ? (ax - px) : (px - ax);
    dy  = (ay >= py) ? (ay - py) : (py - ay);
    dxe = {{CW{1'b0}}, dx};
    dye = {{CW{1'b0}}, dy};
    s   = {1'b0, dxe * dxe} + {1'b0, dye * dye};
    return ({{(31-2*CW){1'b0}}, s} <= 32'(R_SQ));
  endfunction

  always_comb begin
    fix_x     = (state == SCAN1) ? c2x : c1x;
    fix_y     = (state == SCAN1) ? c2y : c1y;
    hit       = covered(cx, cy, pt_x[idx], pt_y[idx]) ||
                covered(fix_x, fix_y, pt_x[idx], pt_y[idx]);
    total     = cnt + CNTW'(hit);
    better    = (total > best);
    last_pt   = (idx == LAST_IDX);
    last_cand = (&cx) && (&cy);
    win_x     = better ? cx : bx;
    win_y     = better ? cy : by;
    iter_next = iter + ITW'(1);
    converged = (c1x == s1x) && (c1y == s1y) && (c2x == s2x) && (c2y == s2y);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      READY     <= 1'b1;
      DONE      <= 1'b0;
      C1X       <= '0;
      C1Y       <= '0;
      C2X       <= '0;
      C2Y       <= '0;
      COUNT     <= '0;
      idx       <= '0;
      cx        <= '0;
      cy        <= '0;
      c1x       <= '0;
      c1y       <= '0;
      c2x       <= '0;
      c2y       <= '0;
      s1x       <= '0;
      s1y       <= '0;
      s2x       <= '0;
      s2y       <= '0;
      bx        <= '0;
      by        <= '0;
      cnt       <= '0;
      best      <= '0;
      final_cnt <= '0;
      iter      <= '0;
      for (int i = 0; i < N_PTS; i++) begin
        pt_x[i] <= '0;
        pt_y[i] <= '0;
      end
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (VALID) begin
            pt_x[idx] <= X;
            pt_y[idx] <= Y;
            if (idx == LAST_IDX) begin
              state <= SCAN1;
              READY <= 1'b0;
              idx   <= '0;
              cx    <= '0;
              cy    <= '0;
              c1x   <= '0;
              c1y   <= '0;
              c2x   <= '0;
              c2y   <= '0;
              s1x   <= '0;
              s1y   <= '0;
              s2x   <= '0;
              s2y   <= '0;
              bx    <= '0;
              by    <= '0;
              cnt   <= '0;
              best  <= '0;
              iter  <= '0;
            end else begin
              state <= LOAD;
              idx   <= idx + IW'(1);
            end
          end
        end

        SCAN1, SCAN2: begin
          if (!last_pt) begin
            idx <= idx + IW'(1);
            cnt <= total;
          end else begin
            idx <= '0;
            cnt <= '0;
            // Strictly greater only, so the earliest candidate keeps a tie.
            if (better) begin
              best <= total;
              bx   <= cx;
              by   <= cy;
            end
            {cy, cx} <= {cy, cx} + (2*CW)'(1);
            if (last_cand) begin
              best <= '0;
              bx   <= '0;
              by   <= '0;
              if (state == SCAN1) begin
                c1x   <= win_x;
                c1y   <= win_y;
                state <= SCAN2;
              end else begin
                c2x       <= win_x;
                c2y       <= win_y;
                final_cnt <= better ? total : best;
                state     <= CHECK;
              end
            end
          end
        end

        CHECK: begin
          iter <= iter_next;
          if (converged || (iter_next == ITER_LIM)) begin
            state <= OUT;
            C1X   <= c1x;
            C1Y   <= c1y;
            C2X   <= c2x;
            C2Y   <= c2y;
            COUNT <= final_cnt;
            DONE  <= 1'b1;
          end else begin
            state <= SCAN1;
            s1x   <= c1x;
            s1y   <= c1y;
            s2x   <= c2x;
            s2y   <= c2y;
          end
        end

        OUT: begin
          state <= IDLE;
          READY <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_laser_cover_gen.sv
`default_nettype none
// tb_laser_cover_gen: five instances run in parallel (defaults, MAX_ITER=1, R_SQ=15) against hand-computed results.

module tb_laser_cover_gen;

  localparam int NU        = 5;
  localparam int SCAN_ITER = 2 * 256 * 40 + 1;

  typedef struct {
    int c1x;
    int c1y;
    int c2x;
    int c2y;
    int cnt;
  } res_t;

  typedef struct {
    int   unit;
    int   pat;
    bit   gaps;
    res_t exp;
    int   iters;
  } vec_t;

  logic                  clk = 1'b0;
  logic [NU-1:0]         rst_n, valid, ready, done;
  logic [NU-1:0][3:0]    xs, ys, c1x, c1y, c2x, c2y;
  logic [NU-1:0][5:0]    cnt;
  int                    total = 0;
  int                    bad   = 0;
  int                    cyc   = 0;
  vec_t                  vecs [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  laser_cover_gen u_a (.CLK(clk), .RST_N(rst_n[0]), .VALID(valid[0]), .X(xs[0]), .Y(ys[0]),
    .READY(ready[0]), .C1X(c1x[0]), .C1Y(c1y[0]), .C2X(c2x[0]), .C2Y(c2y[0]),
    .COUNT(cnt[0]), .DONE(done[0]));
  laser_cover_gen u_b (.CLK(clk), .RST_N(rst_n[1]), .VALID(valid[1]), .X(xs[1]), .Y(ys[1]),
    .READY(ready[1]), .C1X(c1x[1]), .C1Y(c1y[1]), .C2X(c2x[1]), .C2Y(c2y[1]),
    .COUNT(cnt[1]), .DONE(done[1]));
  laser_cover_gen u_c (.CLK(clk), .RST_N(rst_n[2]), .VALID(valid[2]), .X(xs[2]), .Y(ys[2]),
    .READY(ready[2]), .C1X(c1x[2]), .C1Y(c1y[2]), .C2X(c2x[2]), .C2Y(c2y[2]),
    .COUNT(cnt[2]), .DONE(done[2]));
  laser_cover_gen #(.MAX_ITER(1)) u_d (.CLK(clk), .RST_N(rst_n[3]), .VALID(valid[3]),
    .X(xs[3]), .Y(ys[3]), .READY(ready[3]), .C1X(c1x[3]), .C1Y(c1y[3]), .C2X(c2x[3]),
    .C2Y(c2y[3]), .COUNT(cnt[3]), .DONE(done[3]));
  laser_cover_gen #(.R_SQ(15)) u_e (.CLK(clk), .RST_N(rst_n[4]), .VALID(valid[4]),
    .X(xs[4]), .Y(ys[4]), .READY(ready[4]), .C1X(c1x[4]), .C1Y(c1y[4]), .C2X(c2x[4]),
    .C2Y(c2y[4]), .COUNT(cnt[4]), .DONE(done[4]));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Pattern 0: all (3,3). Pattern 1: 20 at (2,2) then 20 at (13,13). Pattern 2: all (4,0).
  task automatic pt(input int pat, input int i, output logic [3:0] px, output logic [3:0] py);
    case (pat)
      0:       begin px = 4'd3; py = 4'd3; end
      1:       begin px = (i < 20) ? 4'd2 : 4'd13; py = px; end
      default: begin px = 4'd4; py = 4'd0; end
    endcase
  endtask

  task automatic send_frame(input int u, input int pat, input bit gaps, output int t0);
    int         i     = 0;
    int         guard = 0;
    bit         g     = 1'b0;
    logic [3:0] px, py;
    while (i < 40 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (gaps && g) begin
        valid[u] = 1'b0;
      end else begin
        pt(pat, i, px, py);
        xs[u]    = px;
        ys[u]    = py;
        valid[u] = 1'b1;
        if (ready[u]) i++;
      end
      g = !g;
    end
    chk($sformatf("u%0d_points_accepted", u), i, 40);
    @(negedge clk);
    valid[u] = 1'b0;
    t0       = cyc;
    chk($sformatf("u%0d_ready_low_in_search", u), int'(ready[u]), 0);
  endtask

  task automatic wait_result(input int u, input res_t e, input int iters, input int t0,
                             input bit hold_en, input res_t h);
    int n    = 0;
    int herr = 0;
    while (n < iters * SCAN_ITER + 50 && !done[u]) begin
      if (hold_en && (int'(c1x[u]) != h.c1x || int'(c1y[u]) != h.c1y ||
                      int'(c2x[u]) != h.c2x || int'(c2y[u]) != h.c2y ||
                      int'(cnt[u]) != h.cnt))
        herr++;
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_done_seen", u), int'(done[u]), 1);
    chk($sformatf("u%0d_latency", u), cyc - t0, iters * SCAN_ITER);
    chk($sformatf("u%0d_c1x", u), int'(c1x[u]), e.c1x);
    chk($sformatf("u%0d_c1y", u), int'(c1y[u]), e.c1y);
    chk($sformatf("u%0d_c2x", u), int'(c2x[u]), e.c2x);
    chk($sformatf("u%0d_c2y", u), int'(c2y[u]), e.c2y);
    chk($sformatf("u%0d_count", u), int'(cnt[u]), e.cnt);
    if (hold_en) chk($sformatf("u%0d_held_outputs_errs", u), herr, 0);
  endtask

  task automatic after_done(input int u, input res_t e);
    @(negedge clk);
    chk($sformatf("u%0d_ready_after_done", u), int'(ready[u]), 1);
    chk($sformatf("u%0d_done_one_cycle", u), int'(done[u]), 0);
    chk($sformatf("u%0d_count_held", u), int'(cnt[u]), e.cnt);
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    send_frame(v.unit, v.pat, v.gaps, t0);
    wait_result(v.unit, v.exp, v.iters, t0, 1'b0, v.exp);
    after_done(v.unit, v.exp);
  endtask

  task automatic seq_a();
    res_t r_bnd = '{0, 0, 0, 0, 40};
    res_t r_33  = '{1, 0, 0, 0, 40};
    int   t0;
    int   de = 0;
    send_frame(0, 2, 1'b0, t0);
    wait_result(0, r_bnd, 1, t0, 1'b0, r_bnd);
    after_done(0, r_bnd);
    send_frame(0, 0, 1'b0, t0);
    repeat (300) begin
      @(negedge clk);
      if (done[0]) de++;
    end
    rst_n[0] = 1'b0;
    #1;
    chk("u0_abort_count_zero", int'(cnt[0]), 0);
    chk("u0_abort_ready", int'(ready[0]), 1);
    chk("u0_abort_outputs_zero", int'({c1x[0], c1y[0], c2x[0], c2y[0], done[0]}), 0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) de++;
    end
    chk("u0_no_done_on_abort", de, 0);
    send_frame(0, 0, 1'b0, t0);
    wait_result(0, r_33, 2, t0, 1'b0, r_33);
    after_done(0, r_33);
  endtask

  task automatic seq_b();
    res_t r_bnd = '{0, 0, 0, 0, 40};
    res_t r_two = '{13, 9, 0, 0, 40};
    int   t0;
    send_frame(1, 2, 1'b0, t0);
    wait_result(1, r_bnd, 1, t0, 1'b0, r_bnd);
    // Frame 2 begins presenting its first point in the cycle right after DONE.
    send_frame(1, 1, 1'b0, t0);
    chk("u1_held_during_load", int'(c1x[1]), 0);
    wait_result(1, r_two, 2, t0, 1'b1, r_bnd);
    after_done(1, r_two);
  endtask

  initial begin
    vecs[0] = '{2, 1, 1'b1, '{13, 9, 0, 0, 40}, 2};
    vecs[1] = '{3, 1, 1'b0, '{13, 9, 0, 0, 40}, 1};
    vecs[2] = '{4, 2, 1'b0, '{1, 0, 0, 0, 40}, 2};

    rst_n = '0;
    valid = '0;
    xs    = '0;
    ys    = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++)
      chk($sformatf("u%0d_reset_state", u),
          int'({c1x[u], c1y[u], c2x[u], c2y[u], cnt[u], ready[u], done[u]}), 2);
    rst_n = '1;

    fork
      seq_a();
      seq_b();
      begin
        for (int k = 0; k < 3; k++) begin
          automatic int kk = k;
          fork
            run_vec(vecs[kk]);
          join_none
        end
        wait fork;
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
